// File: rtl/reject_sampler_stream.sv
// Streaming rejection sampler. It keeps lanes with cand < q, compacts them in order into a
// circular buffer, and emits them as OUT_LANES-wide AXI-stream beats until `target` samples are out.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | accepting input beats until target samples accepted
//   DRAIN | input closed, flushing buffer through tlast
//   DONE  | run complete, done held until next start
module reject_sampler_stream #(
  parameter int LANES     = 4,
  parameter int CAND_BITS = 12,
  parameter int OUT_LANES = 2,
  parameter int DEPTH     = 16,
  parameter int CNT_BITS  = 9
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [CNT_BITS-1:0]            target,
  input  logic [CAND_BITS-1:0]           q,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES*CAND_BITS-1:0]     in_data,
  output logic [LANES-1:0]               acc_bus,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [OUT_LANES*CAND_BITS-1:0] m_tdata,
  output logic [OUT_LANES-1:0]           m_tkeep,
  output logic                           m_tlast,
  output logic                           busy,
  output logic                           done,
  output logic [CNT_BITS-1:0]            produced
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CW       = PTR_BITS + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state;
  logic [CAND_BITS-1:0]  mem [DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr, rd_ptr, rd_idx;
  logic [CW-1:0]         count, n_push, avail;
  logic [CNT_BITS-1:0]   target_r, accepted_total, remaining;
  logic [CAND_BITS-1:0]  q_r;
  logic [LANES-1:0]      keep_mask;
  logic [PTR_BITS-1:0]   widx [LANES];
  logic                  in_fire, out_fire;

  assign remaining = target_r - accepted_total;
  assign in_ready  = (state == RUN) && ((CW'(DEPTH) - count) >= CW'(LANES)) &&
                     (accepted_total < target_r);
  assign in_fire   = in_valid && in_ready;
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);

  // Every lane is compared; the rank among kept lanes gives its buffer slot.
  always_comb begin
    keep_mask = '0;
    n_push    = '0;
    for (int i = 0; i < LANES; i++) begin
      widx[i] = wr_ptr + n_push[PTR_BITS-1:0];
      if ((in_data[i*CAND_BITS +: CAND_BITS] < q_r) && (CNT_BITS'(n_push) < remaining)) begin
        keep_mask[i] = 1'b1;
        n_push       = n_push + CW'(1);
      end
    end
  end

  assign avail    = (count >= CW'(OUT_LANES)) ? CW'(OUT_LANES) : count;
  assign m_tvalid = (count >= CW'(OUT_LANES)) || ((state == DRAIN) && (count != '0));
  assign out_fire = m_tvalid && m_tready;
  assign m_tlast  = m_tvalid && ((produced + CNT_BITS'(avail)) == target_r);

  always_comb begin
    m_tdata = '0;
    m_tkeep = '0;
    rd_idx  = rd_ptr;
    for (int j = 0; j < OUT_LANES; j++) begin
      rd_idx = rd_ptr + PTR_BITS'(j);
      if (m_tvalid && (CW'(j) < avail)) begin
        m_tdata[j*CAND_BITS +: CAND_BITS] = mem[rd_idx];
        m_tkeep[j]                        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int i = 0; i < LANES; i++) begin
        if (keep_mask[i]) mem[widx[i]] <= in_data[i*CAND_BITS +: CAND_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      acc_bus        <= '0;
      produced       <= '0;
      accepted_total <= '0;
      target_r       <= '0;
      q_r            <= '0;
    end else begin
      if (in_fire) begin
        wr_ptr         <= wr_ptr + n_push[PTR_BITS-1:0];
        accepted_total <= accepted_total + CNT_BITS'(n_push);
        acc_bus        <= keep_mask;
      end
      if (out_fire) begin
        rd_ptr   <= rd_ptr + avail[PTR_BITS-1:0];
        produced <= produced + CNT_BITS'(avail);
      end
      count <= count + (in_fire ? n_push : CW'(0)) - (out_fire ? avail : CW'(0));

      case (state)
        IDLE, DONE: begin
          if (start) begin
            target_r       <= target;
            q_r            <= q;
            accepted_total <= '0;
            produced       <= '0;
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            state          <= (target == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (in_fire && ((accepted_total + CNT_BITS'(n_push)) == target_r)) state <= DRAIN;
        end
        DRAIN: begin
          if (out_fire && m_tlast) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reject_sampler_stream.sv
// Randomized bench for reject_sampler_stream: a queue-based model of accepted samples predicts
// every output each cycle; directed runs cover the truncation, backpressure, reset and zero-target cases.
module tb_reject_sampler_stream;
  localparam int LANES = 4, CB = 12, OL = 2, DEPTH = 16, CNTB = 9;

  logic              clk = 0, rst_n = 0, start = 0, in_valid = 0, m_tready = 0;
  logic [CNTB-1:0]   target = '0;
  logic [CB-1:0]     q = '0;
  logic [LANES*CB-1:0] in_data = '0;
  logic              in_ready, m_tvalid, m_tlast, busy, done;
  logic [LANES-1:0]  acc_bus;
  logic [OL*CB-1:0]  m_tdata;
  logic [OL-1:0]     m_tkeep;
  logic [CNTB-1:0]   produced;

  reject_sampler_stream dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target), .q(q),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .acc_bus(acc_bus),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .busy(busy), .done(done), .produced(produced)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: samples accepted but not yet emitted, plus run bookkeeping.
  logic [CB-1:0]    mq[$];
  int               m_tgt = 0, m_q = 0, m_acc = 0, m_prod = 0;
  bit               m_active = 0, m_done = 0;
  logic [LANES-1:0] m_accbus = '0;
  bit               exp_ir, exp_v, exp_last;
  int               n_beat;
  logic [OL*CB-1:0] exp_data;
  logic [OL-1:0]    exp_keep;
  logic [CB-1:0]    lane;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_tgt = 0; m_q = 0; m_acc = 0; m_prod = 0;
      m_active = 0; m_done = 0; m_accbus = '0;
    end else begin
      exp_ir = m_active && (m_acc < m_tgt) && (mq.size() <= DEPTH - LANES);
      exp_v  = m_active && ((mq.size() >= OL) || ((m_acc == m_tgt) && (mq.size() > 0)));
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("in_ready", in_ready, exp_ir);
      check("m_tvalid", m_tvalid, exp_v);
      check("produced", produced, m_prod);
      check("acc_bus", acc_bus, m_accbus);
      n_beat = 0; exp_last = 0; exp_data = '0; exp_keep = '0;
      if (exp_v) begin
        n_beat = (mq.size() < OL) ? mq.size() : OL;
        for (int j = 0; j < n_beat; j++) begin
          exp_data[j*CB +: CB] = mq[j];
          exp_keep[j] = 1'b1;
        end
        exp_last = (m_prod + n_beat == m_tgt);
        check("m_tdata", m_tdata, exp_data);
        check("m_tkeep", m_tkeep, exp_keep);
        check("m_tlast", m_tlast, exp_last);
      end
      if (start && !m_active) begin
        mq.delete();
        m_tgt = int'(target); m_q = int'(q); m_acc = 0; m_prod = 0;
        m_active = (target != 0);
        m_done   = (target == 0);
      end else begin
        if (exp_v && m_tready) begin
          for (int j = 0; j < n_beat; j++) void'(mq.pop_front());
          m_prod += n_beat;
          if (exp_last) begin m_active = 0; m_done = 1; end
        end
        if (exp_ir && in_valid) begin
          for (int i = 0; i < LANES; i++) begin
            lane = in_data[i*CB +: CB];
            m_accbus[i] = (int'(lane) < m_q) && (m_acc < m_tgt);
            if (m_accbus[i]) begin mq.push_back(lane); m_acc++; end
          end
        end
      end
    end
  end

  int tready_mode = 1;
  initial forever begin
    @(posedge clk); #1;
    case (tready_mode)
      0: m_tready = 0;
      1: m_tready = 1;
      default: m_tready = $urandom_range(0, 1);
    endcase
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int t, input int qq);
    start = 1; target = CNTB'(t); q = CB'(qq);
    tick();
    start = 0;
  endtask

  task automatic send_beat(input logic [LANES*CB-1:0] d);
    in_valid = 1; in_data = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        in_valid = 0;
        return;
      end
    end
    in_valid = 0;
    check("in_ready_timeout", in_ready, 1);
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (done) return;
      tick();
    end
    check("done_timeout", done, 1);
  endtask

  task automatic check_reset();
    check("rst_in_ready", in_ready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tkeep", m_tkeep, 0);
    check("rst_acc_bus", acc_bus, 0);
    check("rst_produced", produced, 0);
  endtask

  function automatic logic [LANES*CB-1:0] pack4(input int a, input int b, input int c, input int d);
    return {d[CB-1:0], c[CB-1:0], b[CB-1:0], a[CB-1:0]};
  endfunction

  function automatic logic [LANES*CB-1:0] rand_beat(input int hi);
    return pack4($urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, qq, beats;
    repeat (3) tick();
    check_reset();
    rst_n = 1;
    tick();

    // basic
    do_start(4, 3329);
    send_beat(pack4(100, 3329, 4095, 5));
    check("basic_acc1", acc_bus, 4'b1001);
    send_beat(pack4(3328, 0, 7, 9));
    check("basic_acc2", acc_bus, 4'b0011);
    wait_done(100);
    check("basic_produced", produced, 4);

    // truncation
    do_start(3, 3329);
    send_beat(pack4(1, 2, 3, 4));
    check("trunc_acc", acc_bus, 4'b0111);
    wait_done(100);
    check("trunc_produced", produced, 3);

    // reject-all beat inside a run
    do_start(4, 3329);
    send_beat(pack4(3329, 4000, 3500, 4095));
    check("reject_acc", acc_bus, 4'b0000);
    check("reject_tvalid", m_tvalid, 0);
    send_beat(pack4(1, 2, 3, 4));
    wait_done(100);

    // backpressure, with an ignored start mid-run
    tready_mode = 0;
    do_start(256, 3329);
    fork
      begin
        repeat (5) tick();
        do_start(5, 100);
        repeat (4) tick();
        tready_mode = 2;
      end
      begin
        while (m_active && m_acc < m_tgt) send_beat(rand_beat(3328));
      end
    join
    wait_done(2000);
    check("bp_produced", produced, 256);
    tready_mode = 1;

    // reset mid-run with 6 buffered samples
    tready_mode = 0;
    do_start(20, 3329);
    send_beat(pack4(1, 2, 3, 4000));
    send_beat(pack4(5, 6, 4000, 7));
    tick();
    rst_n = 0;
    tick();
    check_reset();
    rst_n = 1;
    tready_mode = 1;
    do_start(2, 3329);
    send_beat(pack4(10, 4000, 11, 12));
    wait_done(100);
    check("rst_rerun_produced", produced, 2);

    // zero target
    do_start(0, 3329);
    check("zero_done", done, 1);
    in_valid = 1; in_data = pack4(1, 2, 3, 4);
    repeat (5) tick();
    in_valid = 0;

    // random runs
    tready_mode = 2;
    repeat (12) begin
      t  = $urandom_range(1, 40);
      qq = $urandom_range(500, 4095);
      do_start(t, qq);
      beats = 0;
      while (m_active && m_acc < m_tgt && beats < 400) begin
        repeat ($urandom_range(0, 2)) tick();
        send_beat(rand_beat(4095));
        beats++;
      end
      wait_done(500);
    end
    tready_mode = 1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reject_sampler_stream.md
Name: reject_sampler_stream

Overview:
- Parametrised streaming successor to the reject sampler core.
- Takes beats of LANES packed candidates over a valid/ready input and accepts lanes with cand < q.
- Compacts accepted values in order into a DEPTH-entry buffer and emits them as OUT_LANES-wide AXI-stream beats with backpressure.
- Stops after exactly `target` samples, e.g. 256 Kyber coefficients.

Parameters:
- LANES, 4: candidates per input beat.
- CAND_BITS, 12: candidate/sample width.
- OUT_LANES, 2: samples per output beat.
- DEPTH, 16: compaction buffer entries. Power of 2, >= LANES+OUT_LANES.
- CNT_BITS, 9: width of target/produced counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse. Latches target and q, clears counters.
- target  in  CNT_BITS  samples to produce
- q  in  CAND_BITS  modulus/rejection bound
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat ready
- in_data  in  LANES*CAND_BITS  lane i = [i*CAND_BITS +: CAND_BITS]
- acc_bus  out  LANES  registered per-lane accept flags of last input handshake
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- m_tdata  out  OUT_LANES*CAND_BITS  lane 0 (LSB) = oldest sample
- m_tkeep  out  OUT_LANES  valid-lane mask
- m_tlast  out  1  final beat of run
- busy  out  1  state RUN or DRAIN
- done  out  1  state DONE
- produced  out  CNT_BITS  samples emitted so far

Behaviour:
- Reset is synchronous, on rst_n=0 at a clk edge. Reset values:
  - in_ready, m_tvalid, m_tlast, busy, done: 0.
  - m_tdata, m_tkeep, acc_bus, produced: 0.
  - Buffer count and pointers: 0. FSM: IDLE.
- Reset mid-operation discards all buffered data.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> RUN, latching target_r and q_r. If target=0, go to DONE instead.
  - RUN: when accepted_total reaches target_r -> DRAIN.
  - DRAIN: no input. After the tlast handshake -> DONE.
  - DONE: done=1 until next start, then behaves as IDLE start.
  - start in RUN/DRAIN is ignored.
- in_ready = (state==RUN) && (DEPTH-count >= LANES) && (accepted_total < target_r). It uses count at the start of the cycle; a same-cycle pop is not credited.
- On input handshake:
  - All LANES compares are always evaluated (constant time). raw_i = (cand_i < q_r), unsigned.
  - Accepted lanes are kept in lane order, truncated to the first (target_r - accepted_total). Excess accepted lanes are discarded and their acc_bus bit is 0.
  - Kept lanes are written to the buffer tail at the clock edge; acc_bus is updated the same edge.
  - An all-reject beat changes only acc_bus (=0).
- Latency: a sample accepted at edge k can appear on m_tdata in the cycle after edge k.
- m_tvalid = count >= OUT_LANES, or (state==DRAIN && count>0).
  - Beat = min(count, OUT_LANES) oldest entries; unused lanes are 0 with m_tkeep bit 0.
  - m_tlast = 1 when produced + popped == target_r.
- Pop on m_tvalid && m_tready; produced increases by the popped number.
- While m_tvalid && !m_tready, m_tdata, m_tkeep and m_tlast stay stable.
- Push and pop in the same cycle are both performed: count += pushed - popped.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH.
- Arithmetic: count is log2(DEPTH)+1 bits. accepted_total and produced are CNT_BITS bits and never exceed target_r.

Test Plan:
- Basic:
  - Stimulus: q=3329, target=4; beat lanes {100,3329,4095,5}, then {3328,0,7,9}, m_tready=1.
  - Response: acc_bus=4'b1001, then 4'b0011. Beats {100,5} and {3328,0}; tlast on the second. The 7 and 9 in lanes 2-3 of the second beat are accepted by compare but cut by truncation, so they never appear. done=1, produced=4.
- Truncation:
  - Stimulus: target=3, beat {1,2,3,4}.
  - Response: acc_bus=4'b0111. Beats {1,2} keep=2'b11, then {3,0} keep=2'b01 tlast=1. Exactly 3 samples.
- Backpressure:
  - Stimulus: target=256, m_tready=0 for 10 cycles, in_valid=1 with all-accepting beats.
  - Response: in_ready=0 once count>12. count stays <=16, m_tdata stable. On release, samples emerge in order with none lost.
- Reject-all:
  - Stimulus: beat {3329,4000,3500,4095}.
  - Response: acc_bus=0, count unchanged, no new m_tvalid.
- Reset mid-run:
  - Stimulus: rst_n=0 for one edge with 6 buffered samples.
  - Response: all outputs at reset values after that edge. A new start with target=2 then runs normally.
- Zero target:
  - Stimulus: start with target=0.
  - Response: done=1 the next cycle, in_ready and m_tvalid never asserted.
